// File: rtl/line_follow_ctrl.sv
// Line-follower steering FSM: samples three line sensors once per frame,
// owns the frame timebase reset, and picks left/right motor reset/direction.
module line_follow_ctrl #(
    parameter int PERIOD       = 2_000_000,
    parameter int CNT_W        = 21,
    parameter int LOST_PERIODS = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_l,
    input  logic             sensor_m,
    input  logic             sensor_r,
    input  logic [CNT_W-1:0] count,
    output logic             count_reset,
    output logic             motor_l_reset,
    output logic             motor_l_dir,
    output logic             motor_r_reset,
    output logic             motor_r_dir
);

    localparam int LW = $clog2(LOST_PERIODS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [LW-1:0] LOST_MAX = LW'(LOST_PERIODS);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_FWD,
        ST_SOFT_L,
        ST_HARD_L,
        ST_SOFT_R,
        ST_HARD_R
    } state_t;

    // Motor word order: {l_reset, l_dir, r_reset, r_dir}
    localparam logic [3:0] M_STOP = 4'b1010;

    logic [2:0]    sync1;
    logic [2:0]    snap;
    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] lost_cnt;
    logic [LW-1:0] lost_nxt;
    logic [3:0]    mot;
    logic [3:0]    mot_nxt;
    logic          at_end;
    logic          bnd;

    assign at_end      = (count == LAST);
    assign bnd         = reset & at_end;
    assign count_reset = ~reset | at_end;

    assign {motor_l_reset, motor_l_dir, motor_r_reset, motor_r_dir} = mot;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            snap  <= '0;
        end else begin
            sync1 <= {sensor_l, sensor_m, sensor_r};
            snap  <= sync1;
        end
    end

    // Decisions commit only at the frame boundary so PWM pulses stay whole.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_STOP;
            lost_cnt <= '0;
            mot      <= M_STOP;
        end else if (bnd) begin
            state    <= state_nxt;
            lost_cnt <= lost_nxt;
            mot      <= mot_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lost_nxt  = '0;
        mot_nxt   = M_STOP;
        unique case (snap)
            3'b010, 3'b111, 3'b101: state_nxt = ST_FWD;
            3'b110: state_nxt = ST_SOFT_L;
            3'b100: state_nxt = ST_HARD_L;
            3'b011: state_nxt = ST_SOFT_R;
            3'b001: state_nxt = ST_HARD_R;
            default: begin
                lost_nxt = lost_cnt;
                if (lost_cnt != LOST_MAX) begin
                    lost_nxt = lost_cnt + 1'b1;
                end
                if (int'(lost_cnt) + 1 >= LOST_PERIODS) begin
                    state_nxt = ST_STOP;
                end
            end
        endcase
        unique case (state_nxt)
            ST_FWD:    mot_nxt = 4'b0100;
            ST_SOFT_L: mot_nxt = 4'b1000;
            ST_HARD_L: mot_nxt = 4'b0000;
            ST_SOFT_R: mot_nxt = 4'b0110;
            ST_HARD_R: mot_nxt = 4'b0101;
            default:   mot_nxt = M_STOP;
        endcase
    end

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: bench-owned timebase, random sensor frames,
// scoreboard of per-frame motor words checked after each frame boundary.
module tb_line_follow_ctrl;

    localparam int P  = 100;
    localparam int CW = 7;
    localparam int LP = 3;
    localparam logic [3:0] STOP = 4'b1010;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sl = 1'b0;
    logic          sm = 1'b0;
    logic          sr = 1'b0;
    logic [CW-1:0] count = '0;
    logic          count_reset;
    logic          lr, ld, rr, rd;
    wire  [3:0]    mot = {lr, ld, rr, rd};

    int         total = 0;
    int         bad = 0;
    logic [3:0] q[$];
    logic [3:0] cur_exp = STOP;
    logic [3:0] mot_m = STOP;
    int         lost_m = 0;
    logic       bnd_seen = 1'b0;

    line_follow_ctrl #(.PERIOD(P), .CNT_W(CW), .LOST_PERIODS(LP)) dut (
        .clk(clk),
        .reset(reset),
        .sensor_l(sl),
        .sensor_m(sm),
        .sensor_r(sr),
        .count(count),
        .count_reset(count_reset),
        .motor_l_reset(lr),
        .motor_l_dir(ld),
        .motor_r_reset(rr),
        .motor_r_dir(rd)
    );

    always #5 clk = ~clk;

    // Timebase instance stand-in
    always @(posedge clk) count <= count_reset ? '0 : count + 1'b1;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: steering decided by sensor pattern; 000 frames counted.
    task automatic model_step(input logic [2:0] p);
        if (p == 3'b000) begin
            if (lost_m < LP) lost_m++;
            if (lost_m >= LP) mot_m = STOP;
        end else begin
            lost_m = 0;
            case (p)
                3'b110:  mot_m = 4'b1000;
                3'b100:  mot_m = 4'b0000;
                3'b011:  mot_m = 4'b0110;
                3'b001:  mot_m = 4'b0101;
                default: mot_m = 4'b0100;
            endcase
        end
    endtask

    task automatic wait_count(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (count != CW'(k) && n < 400);
        if (count != CW'(k)) begin
            total++;
            bad++;
            $display("FAIL wait_count: got count %0d want %0d", count, k);
        end
        #2;
    endtask

    task automatic frame(input logic [2:0] p, input int k, input bit fresh);
        if (!fresh) wait_count(P - 1);
        wait_count(k);
        {sl, sm, sr} = p;
        model_step(p);
        q.push_back(mot_m);
    endtask

    // Monitor: one scoreboard entry consumed after every frame boundary.
    always @(negedge clk) begin
        if (bnd_seen) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame: got %b want <none queued>", mot);
            end else begin
                cur_exp = q.pop_front();
                check("frame", {4'b0, mot}, {4'b0, cur_exp});
            end
        end else if (reset && count == CW'(P / 2)) begin
            check("midframe", {4'b0, mot}, {4'b0, cur_exp});
        end
        if (reset && count == CW'(P - 1)) begin
            check("count_reset_bnd", {7'b0, count_reset}, 8'h01);
        end
        bnd_seen = reset && (count == CW'(P - 1));
    end

    initial begin
        logic [2:0] p;
        logic [2:0] dir[15];
        int n;
        dir = '{3'b010, 3'b110, 3'b100, 3'b011, 3'b001,
                3'b010, 3'b000, 3'b000, 3'b000, 3'b010,
                3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
        {sl, sm, sr} = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_count_reset", {7'b0, count_reset}, 8'h01);
            check("rst_motors", {4'b0, mot}, {4'b0, STOP});
        end
        check("rst_count", {1'b0, count}, 8'h00);
        #2 reset = 1'b1;

        for (int i = 0; i < 15; i++) frame(dir[i], 40, i == 0);
        for (int i = 0; i < 40; i++) begin
            p = ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom_range(1, 7));
            frame(p, $urandom_range(0, 90), 1'b0);
        end
        frame(3'b001, 20, 1'b0);

        wait_count(P - 1);
        wait_count(57);
        reset = 1'b0;
        #1 check("midrst_count_reset", {7'b0, count_reset}, 8'h01);
        @(negedge clk);
        check("midrst_motors", {4'b0, mot}, {4'b0, STOP});
        check("midrst_count", {1'b0, count}, 8'h00);
        cur_exp = STOP;
        lost_m = 0;
        mot_m = STOP;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("restart_count", {1'b0, count}, 8'h02);

        for (int i = 0; i < 12; i++) begin
            p = ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom_range(1, 7));
            frame(p, $urandom_range(0, 90), i == 0);
        end

        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 8'(q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
